// File: rtl/gpio_trigger_pkg.sv
// gpio_trigger_pkg
//   Shared definitions for the GPIO trigger follower: FSM state encoding,
//   header pin index constants and a counter-width helper.
package gpio_trigger_pkg;

  // Trigger FSM states (2-bit encoding, values fixed for software visibility)
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2
  } trig_state_e;

  // Input pin indices on the header
  localparam int unsigned TRIG_IN_PIN  = 0;
  localparam int unsigned AUX_IN_PIN   = 1;

  // Output pin offsets, relative to the first output pin (GPIO_INPUT_WIDTH)
  localparam int unsigned REQ_OUT_OFS  = 0;
  localparam int unsigned TRIG_OUT_OFS = 1;

  // Width needed to hold values 0..max_val (never less than 1 bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((2 ** w) <= max_val) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/gpio_input_filter.sv
// gpio_input_filter
//   Two-flop synchroniser followed by a glitch filter: the filtered level only
//   changes after the synchronised input has differed from it for FILTER_LEN
//   consecutive cycles. Any shorter excursion is discarded.
// Ports
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset
//   pin_i   in   raw asynchronous pin level
//   filt_o  out  filtered level (registered)
module gpio_input_filter
  import gpio_trigger_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic filt_o
);

  // Counter only needs to reach FILTER_LEN-1; the flip happens instead of the
  // increment that would reach FILTER_LEN.
  localparam int unsigned    CW       = cnt_width(FILTER_LEN - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic          filt_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Glitch counter and filtered-level next state
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchroniser, counter and filtered level registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/gpio_trigger_slave.sv
// gpio_trigger_slave
//   Follower end of the GPIO trigger link. Filters the trigger and aux input
//   pins, latches a level trigger with a capture timestamp when armed, and
//   drives a stretched request pin plus a trigger echo pin back to the master.
// Ports
//   aclk        in     clock, rising edge
//   areset      in     synchronous active-high reset
//   gpio_data   inout  header pins; [GPIO_INPUT_WIDTH-1:0] inputs, rest outputs
//   arm         in     pulse, arm / re-arm
//   disarm      in     pulse, return to IDLE
//   soft_trig   in     pulse, local trigger and request to master
//   trigger     out    high while TRIGGERED
//   trig_pulse  out    one-cycle pulse on entry to TRIGGERED
//   armed       out    high while ARMED
//   ext_aux     out    filtered aux pin level
//   ts_data     out    timestamp captured at trigger
//   ts_valid    out    ts_data valid; cleared by arm/disarm
module gpio_trigger_slave
  import gpio_trigger_pkg::*;
#(
  parameter int unsigned GPIO_DATA_WIDTH  = 8,
  parameter int unsigned GPIO_INPUT_WIDTH = 2,
  parameter int unsigned FILTER_LEN       = 4,
  parameter int unsigned REQ_LEN          = 8,
  parameter int unsigned TS_WIDTH         = 32
) (
  input  logic                       aclk,
  input  logic                       areset,
  inout  wire  [GPIO_DATA_WIDTH-1:0] gpio_data,
  input  logic                       arm,
  input  logic                       disarm,
  input  logic                       soft_trig,
  output logic                       trigger,
  output logic                       trig_pulse,
  output logic                       armed,
  output logic                       ext_aux,
  output logic [TS_WIDTH-1:0]        ts_data,
  output logic                       ts_valid
);

  localparam int unsigned RW       = cnt_width(REQ_LEN);
  localparam int unsigned REQ_IDX  = GPIO_INPUT_WIDTH + REQ_OUT_OFS;
  localparam int unsigned TRIG_IDX = GPIO_INPUT_WIDTH + TRIG_OUT_OFS;

  logic [GPIO_INPUT_WIDTH-1:0] filt_s;
  logic                        filt_dly_q;
  logic                        trig_edge_s;

  trig_state_e   state_q;
  trig_state_e   state_d;
  logic          fire_s;
  logic          clear_ts_s;

  logic [TS_WIDTH-1:0] ts_cnt_q;
  logic [TS_WIDTH-1:0] ts_data_q;
  logic                ts_valid_q;
  logic                trigger_q;
  logic                trig_pulse_q;
  logic                armed_q;

  logic [RW-1:0] req_cnt_q;
  logic [RW-1:0] req_cnt_d;
  logic          req_pin_q;
  logic          trig_pin_q;

  logic [GPIO_DATA_WIDTH-1:0] pin_out_s;
  logic [GPIO_DATA_WIDTH-1:0] pin_oe_s;

  // One filter per input pin
  for (genvar gi = 0; gi < GPIO_INPUT_WIDTH; gi++) begin : g_in
    gpio_input_filter #(
      .FILTER_LEN (FILTER_LEN)
    ) u_filt (
      .clk_i  (aclk),
      .rst_i  (areset),
      .pin_i  (gpio_data[gi]),
      .filt_o (filt_s[gi])
    );
  end

  assign trig_edge_s = filt_s[TRIG_IN_PIN] & ~filt_dly_q;

  // Trigger FSM next state; edges in IDLE/TRIGGERED fall through unused
  always_comb begin
    state_d    = state_q;
    fire_s     = 1'b0;
    clear_ts_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (disarm) begin
          state_d    = ST_IDLE;
          clear_ts_s = 1'b1;
        end else if (arm) begin
          state_d    = ST_ARMED;
          clear_ts_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          state_d    = ST_IDLE;
          clear_ts_s = 1'b1;
        end else if (trig_edge_s || soft_trig) begin
          // a trigger source outranks a same-cycle arm
          state_d = ST_TRIGGERED;
          fire_s  = 1'b1;
        end else if (arm) begin
          state_d    = ST_ARMED;
          clear_ts_s = 1'b1;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_TRIGGERED: begin
        if (disarm) begin
          state_d    = ST_IDLE;
          clear_ts_s = 1'b1;
        end else if (arm) begin
          state_d    = ST_ARMED;
          clear_ts_s = 1'b1;
        end else begin
          state_d = ST_TRIGGERED;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        clear_ts_s = 1'b1;
      end
    endcase
  end

  // Request stretch counter: soft_trig reloads, otherwise count down to 0
  always_comb begin
    req_cnt_d = req_cnt_q;
    if (soft_trig) begin
      req_cnt_d = RW'(REQ_LEN);
    end else if (req_cnt_q != '0) begin
      req_cnt_d = req_cnt_q - RW'(1);
    end else begin
      req_cnt_d = '0;
    end
  end

  // State, timestamp, status outputs and output pin registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      filt_dly_q   <= 1'b0;
      ts_cnt_q     <= '0;
      ts_data_q    <= '0;
      ts_valid_q   <= 1'b0;
      trigger_q    <= 1'b0;
      trig_pulse_q <= 1'b0;
      armed_q      <= 1'b0;
      req_cnt_q    <= '0;
      req_pin_q    <= 1'b0;
      trig_pin_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      filt_dly_q   <= filt_s[TRIG_IN_PIN];
      ts_cnt_q     <= ts_cnt_q + TS_WIDTH'(1);
      if (fire_s) begin
        // capture the count as it stood before this edge's increment
        ts_data_q  <= ts_cnt_q;
        ts_valid_q <= 1'b1;
      end else if (clear_ts_s) begin
        ts_valid_q <= 1'b0;
      end else begin
        ts_valid_q <= ts_valid_q;
      end
      trigger_q    <= (state_d == ST_TRIGGERED);
      trig_pulse_q <= fire_s;
      armed_q      <= (state_d == ST_ARMED);
      req_cnt_q    <= req_cnt_d;
      req_pin_q    <= (req_cnt_d != '0);
      trig_pin_q   <= (state_d == ST_TRIGGERED);
    end
  end

  // Header pin output values and enables (inputs tri-stated)
  always_comb begin
    pin_out_s           = '0;
    pin_oe_s            = '1;
    pin_out_s[REQ_IDX]  = req_pin_q;
    pin_out_s[TRIG_IDX] = trig_pin_q;
    for (int i = 0; i < GPIO_INPUT_WIDTH; i++) begin
      pin_oe_s[i] = 1'b0;
    end
  end

  // Per-pin IOBUF
  for (genvar gp = 0; gp < GPIO_DATA_WIDTH; gp++) begin : g_iobuf
    assign gpio_data[gp] = pin_oe_s[gp] ? pin_out_s[gp] : 1'bz;
  end

  assign trigger    = trigger_q;
  assign trig_pulse = trig_pulse_q;
  assign armed      = armed_q;
  assign ext_aux    = filt_s[AUX_IN_PIN];
  assign ts_data    = ts_data_q;
  assign ts_valid   = ts_valid_q;

endmodule

// File: tb/tb_gpio_trigger_slave.sv
// tb_gpio_trigger_slave
//   Directed bench for gpio_trigger_slave. Edge 0 is the reset edge; after it
//   the free-running timestamp equals the number of the last clock edge.
//   Inputs change on the falling edge before edge N; outputs are sampled on
//   the falling edge after edge N.
module tb_gpio_trigger_slave;

  logic        aclk;
  logic        areset;
  logic        arm;
  logic        disarm;
  logic        soft_trig;
  logic        pin0_r;
  logic        pin1_r;
  wire  [7:0]  gpio;
  logic        trigger;
  logic        trig_pulse;
  logic        armed;
  logic        ext_aux;
  logic [31:0] ts_data;
  logic        ts_valid;

  int checks;
  int errors;
  int edge_n;

  assign gpio[0] = pin0_r;
  assign gpio[1] = pin1_r;

  gpio_trigger_slave #(
    .GPIO_DATA_WIDTH  (8),
    .GPIO_INPUT_WIDTH (2),
    .FILTER_LEN       (4),
    .REQ_LEN          (8),
    .TS_WIDTH         (32)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .gpio_data  (gpio),
    .arm        (arm),
    .disarm     (disarm),
    .soft_trig  (soft_trig),
    .trigger    (trigger),
    .trig_pulse (trig_pulse),
    .armed      (armed),
    .ext_aux    (ext_aux),
    .ts_data    (ts_data),
    .ts_valid   (ts_valid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance until just after edge e (sampled on the following falling edge)
  task automatic go_to(input int e);
    while (edge_n < e) begin
      @(posedge aclk);
      edge_n = edge_n + 1;
    end
    @(negedge aclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    edge_n    = -1;
    areset    = 1'b1;
    arm       = 1'b0;
    disarm    = 1'b0;
    soft_trig = 1'b0;
    pin0_r    = 1'b0;
    pin1_r    = 1'b0;

    // Reset state
    go_to(0);
    chk("rst_trigger",  {31'd0, trigger},    32'd0);
    chk("rst_pulse",    {31'd0, trig_pulse}, 32'd0);
    chk("rst_armed",    {31'd0, armed},      32'd0);
    chk("rst_aux",      {31'd0, ext_aux},    32'd0);
    chk("rst_ts_data",  ts_data,             32'd0);
    chk("rst_ts_valid", {31'd0, ts_valid},   32'd0);
    chk("rst_outpins",  {26'd0, gpio[7:2]},  32'd0);
    areset = 1'b0;

    // 1: arm at 10, pin0 high from edge 20 -> trigger after edge 26, ts 25
    go_to(9);  arm = 1'b1;
    go_to(10); arm = 1'b0;
    chk("t1_armed", {31'd0, armed}, 32'd1);
    go_to(19); pin0_r = 1'b1;
    go_to(25);
    chk("t1_trig_early", {31'd0, trigger}, 32'd0);
    go_to(26);
    chk("t1_trigger",  {31'd0, trigger},    32'd1);
    chk("t1_pulse",    {31'd0, trig_pulse}, 32'd1);
    chk("t1_ts_data",  ts_data,             32'd25);
    chk("t1_ts_valid", {31'd0, ts_valid},   32'd1);
    chk("t1_trig_pin", {31'd0, gpio[3]},    32'd1);
    chk("t1_armed_lo", {31'd0, armed},      32'd0);
    go_to(27);
    chk("t1_pulse_end", {31'd0, trig_pulse}, 32'd0);
    chk("t1_trig_hold", {31'd0, trigger},    32'd1);

    // 3: disarm, then soft_trig at 35 and 39 while IDLE
    go_to(29); disarm = 1'b1;
    go_to(30); disarm = 1'b0; pin0_r = 1'b0;
    chk("t3_disarm_trig",  {31'd0, trigger},  32'd0);
    chk("t3_disarm_valid", {31'd0, ts_valid}, 32'd0);
    go_to(34); soft_trig = 1'b1;
    chk("t3_req_before", {31'd0, gpio[2]}, 32'd0);
    go_to(35); soft_trig = 1'b0;
    chk("t3_req_start", {31'd0, gpio[2]}, 32'd1);
    go_to(38); soft_trig = 1'b1;
    go_to(39); soft_trig = 1'b0;
    go_to(40);
    chk("t3_idle_trig", {31'd0, trigger}, 32'd0);
    go_to(45);
    chk("t3_req_reload", {31'd0, gpio[2]}, 32'd1);
    go_to(46);
    chk("t3_req_last", {31'd0, gpio[2]}, 32'd1);
    go_to(47);
    chk("t3_req_end", {31'd0, gpio[2]}, 32'd0);

    // 2: armed, 3-cycle pulse rejected, 4-cycle pulse accepted
    go_to(49); arm = 1'b1;
    go_to(50); arm = 1'b0;
    go_to(51); pin0_r = 1'b1;
    go_to(54); pin0_r = 1'b0;
    go_to(62);
    chk("t2_short_trig",  {31'd0, trigger}, 32'd0);
    chk("t2_short_armed", {31'd0, armed},   32'd1);
    go_to(63); pin0_r = 1'b1;
    go_to(67); pin0_r = 1'b0;
    go_to(69);
    chk("t2_long_early", {31'd0, trigger}, 32'd0);
    go_to(70);
    chk("t2_long_trig", {31'd0, trigger}, 32'd1);
    chk("t2_long_ts",   ts_data,          32'd69);

    // 4a: arm and disarm together -> IDLE
    go_to(74); arm = 1'b1; disarm = 1'b1;
    go_to(75); arm = 1'b0; disarm = 1'b0;
    chk("t4_ad_armed", {31'd0, armed},   32'd0);
    chk("t4_ad_trig",  {31'd0, trigger}, 32'd0);
    // 4b: armed, arm in the same cycle as the pin0 edge -> TRIGGERED
    go_to(76); arm = 1'b1;
    go_to(77); arm = 1'b0;
    chk("t4_armed", {31'd0, armed}, 32'd1);
    go_to(79); pin0_r = 1'b1;
    go_to(85); arm = 1'b1;
    go_to(86); arm = 1'b0;
    chk("t4_edge_wins", {31'd0, trigger},  32'd1);
    chk("t4_armed_lo",  {31'd0, armed},    32'd0);
    chk("t4_ts",        ts_data,           32'd85);

    // 5: re-arm while pin0 held high, no retrigger until a fresh edge
    go_to(89); arm = 1'b1;
    go_to(90); arm = 1'b0;
    chk("t5_rearm_trig",  {31'd0, trigger},  32'd0);
    chk("t5_rearm_armed", {31'd0, armed},    32'd1);
    chk("t5_rearm_valid", {31'd0, ts_valid}, 32'd0);
    go_to(99); pin0_r = 1'b0;
    chk("t5_held_trig", {31'd0, trigger}, 32'd0);
    go_to(109); pin0_r = 1'b1;
    go_to(115);
    chk("t5_fresh_early", {31'd0, trigger}, 32'd0);
    go_to(116);
    chk("t5_fresh_trig", {31'd0, trigger}, 32'd1);
    chk("t5_fresh_ts",   ts_data,          32'd115);

    // 6: reset during request stretch and TRIGGERED
    go_to(117); soft_trig = 1'b1;
    go_to(118); soft_trig = 1'b0;
    chk("t6_req_on", {31'd0, gpio[2]}, 32'd1);
    go_to(119); areset = 1'b1;
    go_to(120); areset = 1'b0;
    chk("t6_trigger", {31'd0, trigger},   32'd0);
    chk("t6_armed",   {31'd0, armed},     32'd0);
    chk("t6_valid",   {31'd0, ts_valid},  32'd0);
    chk("t6_ts_data", ts_data,            32'd0);
    chk("t6_pins",    {26'd0, gpio[7:2]}, 32'd0);

    // aux filtered level follows pin1 after the filter latency
    go_to(129); pin1_r = 1'b1;
    go_to(134);
    chk("aux_early", {31'd0, ext_aux}, 32'd0);
    go_to(135);
    chk("aux_high", {31'd0, ext_aux}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
